// File: rtl/hex_display_scanner.sv
//------------------------------------------------------------------------------
// hex_display_scanner
// Multiplexed 8-digit seven-segment driver. It shows a 32-bit word as
// hexadecimal. Writes are double-buffered so that the displayed value only
// changes at a frame boundary.
// Optional feature macro: HEX_DISP_BLANK_EN (leading-zero blanking).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_display_scanner #(
    parameter int DIGIT_CYCLES = 50000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        frame_o
);

    localparam logic [15:0] PRESC_LAST = 16'(DIGIT_CYCLES - 1);

    logic [15:0] presc;
    logic [2:0]  idx;
    logic [31:0] pending;
    logic        pend_vld;
    logic [31:0] shown;
    logic        digit_end;
    logic        boundary;
    logic [3:0]  nibble;
    logic [6:0]  seg_raw;
    logic [7:0]  an_raw;

    assign digit_end = (presc == PRESC_LAST);
    assign boundary  = digit_end && (idx == 3'd7);

    // Prescaler, digit index and frame-start pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc   <= 16'd0;
            idx     <= 3'd0;
            frame_o <= 1'b0;
        end else begin
            frame_o <= boundary;
            if (digit_end) begin
                presc <= 16'd0;
                idx   <= idx + 3'd1;
            end else begin
                presc <= presc + 16'd1;
            end
        end
    end

    // Write buffer and frame buffer; a write on the boundary edge goes
    // straight to the frame buffer but is also latched as a normal write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending  <= 32'd0;
            pend_vld <= 1'b0;
            shown    <= 32'd0;
        end else begin
            if (boundary) begin
                if (we_i) begin
                    shown <= data_i;
                end else if (pend_vld) begin
                    shown <= pending;
                end
            end
            if (we_i) begin
                pending  <= data_i;
                pend_vld <= 1'b1;
            end else if (boundary) begin
                pend_vld <= 1'b0;
            end
        end
    end

    assign nibble = shown[{idx, 2'b00} +: 4];
    assign an_raw = ~(8'd1 << idx);

    // Active-low hex decode, segment order {g,f,e,d,c,b,a}
    always_comb begin
        seg_raw = 7'b1111111;
        case (nibble)
            4'h0: seg_raw = 7'b1000000;
            4'h1: seg_raw = 7'b1111001;
            4'h2: seg_raw = 7'b0100100;
            4'h3: seg_raw = 7'b0110000;
            4'h4: seg_raw = 7'b0011001;
            4'h5: seg_raw = 7'b0010010;
            4'h6: seg_raw = 7'b0000010;
            4'h7: seg_raw = 7'b1111000;
            4'h8: seg_raw = 7'b0000000;
            4'h9: seg_raw = 7'b0010000;
            4'hA: seg_raw = 7'b0001000;
            4'hB: seg_raw = 7'b0000011;
            4'hC: seg_raw = 7'b1000110;
            4'hD: seg_raw = 7'b0100001;
            4'hE: seg_raw = 7'b0000110;
            4'hF: seg_raw = 7'b0001110;
            default: seg_raw = 7'b1111111;
        endcase
    end

`ifdef HEX_DISP_BLANK_EN
    logic [7:0] lit;

    // A digit lights when it or any more-significant digit is non-zero;
    // digit 0 always lights so that zero still shows one "0"
    always_comb begin
        lit    = 8'h00;
        lit[0] = 1'b1;
        for (int i = 1; i < 8; i++) begin
            lit[i] = |(shown >> (4 * i));
        end
    end

    assign an_o  = lit[idx] ? an_raw  : 8'hFF;
    assign seg_o = lit[idx] ? seg_raw : 7'b1111111;
`else
    assign an_o  = an_raw;
    assign seg_o = seg_raw;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
//------------------------------------------------------------------------------
// tb_hex_display_scanner
// Scoreboard bench: the stimulus pushes the value each frame must show. The
// monitor pops one entry per frame_o pulse and checks every cycle of it.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = 32'd0;
    logic        we = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb[$];

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    hex_display_scanner #(.DIGIT_CYCLES(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data),
        .we_i    (we),
        .an_o    (an),
        .seg_o   (seg),
        .frame_o (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_an(input logic [31:0] v, input int d);
`ifdef HEX_DISP_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 32'd0) return 8'hFF;
`endif
        return ~(8'd1 << d);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [31:0] v, input int d);
`ifdef HEX_DISP_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 32'd0) return 7'b1111111;
`endif
        return hex_tab[(v >> (4 * d)) & 32'hF];
    endfunction

    task automatic wr(input logic [31:0] v);
        we   = 1'b1;
        data = v;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame && n < 100);
        check("frame_timeout", {31'd0, frame}, 32'd1);
    endtask

    // Monitor: one scoreboard entry per frame, checked over all 32 cycles
    initial begin
        logic [31:0] val;
        forever begin
            @(negedge clk);
            if (!rst && frame) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    val = sb.pop_front();
                    for (int k = 0; k < 32; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst) break;
                        check("frame_an",  {24'd0, an},  {24'd0, exp_an(val, k / 4)});
                        check("frame_seg", {25'd0, seg}, {25'd0, exp_seg(val, k / 4)});
                        check("frame_pulse", {31'd0, frame}, (k == 0) ? 32'd1 : 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset held for 3 cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_an",  {24'd0, an},  32'h0000_00FE);
            check("rst_seg", {25'd0, seg}, 32'h0000_0040);
        end
        sb.push_back(32'h0000_0000);
        rst = 1'b0;
        check("rel_an",  {24'd0, an},  32'h0000_00FE);
        check("rel_seg", {25'd0, seg}, 32'h0000_0040);
        check("rel_frame", {31'd0, frame}, 32'd0);
        wait_frame(n);
        check("first_frame_cycle", n, 32);

        // Decode: mid-frame write
        repeat (10) @(negedge clk);
        sb.push_back(32'h89AB_CDEF);
        wr(32'h89AB_CDEF);
        wait_frame(n);

        // No tearing
        repeat (5) @(negedge clk);
        sb.push_back(32'h1111_1111);
        wr(32'h1111_1111);
        wait_frame(n);
        repeat (13) @(negedge clk);
        check("idx3_an", {24'd0, an}, 32'h0000_00F7);
        sb.push_back(32'h2222_2222);
        wr(32'h2222_2222);
        wait_frame(n);

        // Last write wins
        repeat (3) @(negedge clk);
        wr(32'h5);
        repeat (4) @(negedge clk);
        sb.push_back(32'h6);
        wr(32'h6);
        wait_frame(n);

        // Write on the boundary edge bypasses the buffer
        repeat (31) @(negedge clk);
        sb.push_back(32'h7);
        wr(32'h7);
        check("bypass_frame", {31'd0, frame}, 32'd1);
        check("bypass_seg", {25'd0, seg}, 32'h0000_0078);
        sb.push_back(32'h7);
        wait_frame(n);

        // Async reset mid-scan
        repeat (2) @(negedge clk);
        sb.push_back(32'hDEAD_BEEF);
        wr(32'hDEAD_BEEF);
        wait_frame(n);
        repeat (3) @(negedge clk);
        wr(32'h1234_5678);
        repeat (17) @(negedge clk);
        check("idx5_an", {24'd0, an}, 32'h0000_00DF);
        #2 rst = 1'b1;
        #1;
        check("async_an",  {24'd0, an},  32'h0000_00FE);
        check("async_seg", {25'd0, seg}, 32'h0000_0040);
        sb.push_back(32'h0000_0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_frame(n);
        check("post_rst_frame_cycle", n, 32);

        // Leading-zero value (blanked only when the macro is defined)
        repeat (2) @(negedge clk);
        sb.push_back(32'h0000_00A0);
        wr(32'h0000_00A0);
        wait_frame(n);
        repeat (31) @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
